// File: rtl/alu_pkg.sv
// Shared types for the ALU command issuer slice.
//   OPC_W / OPD_W : opcode and operand widths of the alu block
//   state_t       : issuer FSM states
//   alu_cmd_t     : one buffered command {opcode, op1, op2}
package alu_pkg;

  localparam int OPC_W = 3;
  localparam int OPD_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [OPD_W-1:0] op1;
    logic [OPD_W-1:0] op2;
  } alu_cmd_t;

  localparam int CMD_W = $bits(alu_cmd_t);

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Bundle of the three streams around the issuer:
//   cmd_*  : command stream in (valid/ready)
//   alu_*  : operand drive to the alu block and its result back
//   rsp_*  : response stream out (valid/ready)
// master = issuer view, slave = command source / alu / response sink view.
interface alu_cmd_issuer_if #(
  parameter int RES_W = 4
);
  import alu_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [OPC_W-1:0] cmd_opcode;
  logic [OPD_W-1:0] cmd_op1;
  logic [OPD_W-1:0] cmd_op2;

  logic [OPC_W-1:0] alu_opcode;
  logic [OPD_W-1:0] alu_op1;
  logic [OPD_W-1:0] alu_op2;
  logic [RES_W-1:0] alu_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [RES_W-1:0] rsp_result;
  logic [OPC_W-1:0] rsp_opcode;

  modport master (
    input  cmd_valid, cmd_opcode, cmd_op1, cmd_op2, alu_result, rsp_ready,
    output cmd_ready, alu_opcode, alu_op1, alu_op2, rsp_valid, rsp_result, rsp_opcode
  );

  modport slave (
    output cmd_valid, cmd_opcode, cmd_op1, cmd_op2, alu_result, rsp_ready,
    input  cmd_ready, alu_opcode, alu_op1, alu_op2, rsp_valid, rsp_result, rsp_opcode
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Small synchronous command FIFO.
//   clk, rstn    : clock, synchronous active-low reset (pointers/count cleared)
//   push, din    : write din when push and not full
//   pop, dout    : dout is the current head; pop advances it when not empty
//   full, empty  : derived from the occupancy count
//   count        : occupancy, 0..DEPTH
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_reg[rd_ptr_reg];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (rstn && push_ok) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Initiator for the alu operand interface. Buffers commands, issues one at a
// time to the alu, waits ALU_LAT edges, captures the result and offers it on
// the response stream.
//   clk  : clock
//   rstn : synchronous active-low reset; abandons buffered/in-flight commands
//   bus  : command, alu and response signals (master view)
//   busy : FSM not idle or commands still buffered
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int RES_W   = 4
) (
  input  logic               clk,
  input  logic               rstn,
  alu_cmd_issuer_if.master   bus,
  output logic               busy
);

  localparam logic [3:0] LAT = 4'(ALU_LAT);

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  alu_cmd_t         issued_reg, issued_next;
  logic             rsp_valid_reg, rsp_valid_next;
  logic [RES_W-1:0] rsp_result_reg, rsp_result_next;
  logic [OPC_W-1:0] rsp_opcode_reg, rsp_opcode_next;
  logic             rstn_q_reg;

  alu_cmd_t                  push_cmd;
  alu_cmd_t                  head_cmd;
  logic                      push;
  logic                      pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [$clog2(DEPTH):0]    fifo_count;

  // rstn_q holds cmd_ready low for the first cycle after reset release.
  assign bus.cmd_ready = rstn_q_reg && !fifo_full;
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign push_cmd      = {bus.cmd_opcode, bus.cmd_op1, bus.cmd_op2};

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (push_cmd),
    .pop   (pop),
    .dout  (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      issued_reg     <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_result_reg <= '0;
      rsp_opcode_reg <= '0;
      rstn_q_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      issued_reg     <= issued_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_result_reg <= rsp_result_next;
      rsp_opcode_reg <= rsp_opcode_next;
      rstn_q_reg     <= 1'b1;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    issued_next     = issued_reg;
    rsp_valid_next  = rsp_valid_reg;
    rsp_result_next = rsp_result_reg;
    rsp_opcode_next = rsp_opcode_reg;
    pop             = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          issued_next = head_cmd;
          cnt_next    = LAT;
          state_next  = WAIT;
        end else begin
          issued_next = '0;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        // The issued command doubles as the alu drive, so clearing it
        // returns alu_* to 0 while the opcode is latched for the echo.
        if (cnt_reg == 4'd1) begin
          rsp_result_next = bus.alu_result;
          rsp_opcode_next = issued_reg.opcode;
          rsp_valid_next  = 1'b1;
          issued_next     = '0;
          state_next      = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.alu_opcode = issued_reg.opcode;
  assign bus.alu_op1    = issued_reg.op1;
  assign bus.alu_op2    = issued_reg.op2;
  assign bus.rsp_valid  = rsp_valid_reg;
  assign bus.rsp_result = rsp_result_reg;
  assign bus.rsp_opcode = rsp_opcode_reg;
  assign busy           = (state_reg != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer. dut1 (ALU_LAT=1) carries the
// directed and randomized traffic with an in-order response scoreboard;
// dut3 (ALU_LAT=3) is used for the reset-during-WAIT scenario.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rstn1;
  logic rstn3;
  logic busy1;
  logic busy3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] opc;
    logic [3:0] res;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_cmd_issuer_if #(.RES_W(4)) i1 ();
  alu_cmd_issuer_if #(.RES_W(4)) i3 ();

  // ALU stubs: result = OP1 + OP2 mod 16, settled well before the capture edge.
  assign i1.alu_result = 4'(i1.alu_op1 + i1.alu_op2);
  assign i3.alu_result = 4'(i3.alu_op1 + i3.alu_op2);

  alu_cmd_issuer #(.DEPTH(4), .ALU_LAT(1), .RES_W(4)) dut1 (
    .clk (clk), .rstn (rstn1), .bus (i1), .busy (busy1)
  );

  alu_cmd_issuer #(.DEPTH(4), .ALU_LAT(3), .RES_W(4)) dut3 (
    .clk (clk), .rstn (rstn3), .bus (i3), .busy (busy3)
  );

  function automatic logic [3:0] model_sum(input logic [3:0] a, input logic [3:0] b);
    return 4'((int'(a) + int'(b)) % 16);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; before the edge, log dut1 handshakes into the model.
  task automatic step();
    exp_t e;
    if (i1.rsp_valid && i1.rsp_ready) begin
      check("sb_expected_any", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_rsp_opcode", 32'(i1.rsp_opcode), 32'(e.opc));
        check("sb_rsp_result", 32'(i1.rsp_result), 32'(e.res));
        $display("rsp opcode=%0d result=%0h", i1.rsp_opcode, i1.rsp_result);
      end
    end
    if (i1.cmd_valid && i1.cmd_ready) begin
      e.opc = i1.cmd_opcode;
      e.res = model_sum(i1.cmd_op1, i1.cmd_op2);
      exp_q.push_back(e);
      $display("cmd opcode=%0d op1=%0h op2=%0h", i1.cmd_opcode, i1.cmd_op1, i1.cmd_op2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd1(input logic [2:0] opc, input logic [3:0] a, input logic [3:0] b);
    i1.cmd_opcode = opc;
    i1.cmd_op1    = a;
    i1.cmd_op2    = b;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    i1.cmd_valid = 1'b0;
    i1.rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || busy1) && n < 100) begin
      step();
      n++;
    end
    check({tag, "_drained"}, 32'(n < 100), 1);
  endtask

  task automatic single_op(input logic [2:0] opc, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    r = model_sum(a, b);
    i1.rsp_ready = 1'b1;
    set_cmd1(opc, a, b);
    i1.cmd_valid = 1'b1;
    check("single_cmd_ready", 32'(i1.cmd_ready), 1);
    step();                                   // E0: accept
    i1.cmd_valid = 1'b0;
    check("e0_rsp_valid", 32'(i1.rsp_valid), 0);
    check("e0_busy", 32'(busy1), 1);
    step();                                   // E1: issue
    check("e1_alu_opcode", 32'(i1.alu_opcode), 32'(opc));
    check("e1_alu_op1", 32'(i1.alu_op1), 32'(a));
    check("e1_alu_op2", 32'(i1.alu_op2), 32'(b));
    check("e1_rsp_valid", 32'(i1.rsp_valid), 0);
    step();                                   // E2: capture
    check("e2_rsp_valid", 32'(i1.rsp_valid), 1);
    check("e2_rsp_result", 32'(i1.rsp_result), 32'(r));
    check("e2_rsp_opcode", 32'(i1.rsp_opcode), 32'(opc));
    check("e2_alu_opcode", 32'(i1.alu_opcode), 0);
    step();                                   // E3: response taken
    check("e3_rsp_valid", 32'(i1.rsp_valid), 0);
    check("e3_busy", 32'(busy1), 0);
  endtask

  initial begin
    logic [2:0] q_opc [3];
    rstn1 = 1'b0;
    rstn3 = 1'b0;
    i1.cmd_valid = 1'b0; i1.rsp_ready = 1'b0; set_cmd1(3'd0, 4'd0, 4'd0);
    i3.cmd_valid = 1'b0; i3.rsp_ready = 1'b0;
    i3.cmd_opcode = 3'd0; i3.cmd_op1 = 4'd0; i3.cmd_op2 = 4'd0;

    // Reset and release.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_cmd_ready", 32'(i1.cmd_ready), 0);
    check("rst_alu_opcode", 32'(i1.alu_opcode), 0);
    check("rst_alu_op1", 32'(i1.alu_op1), 0);
    check("rst_alu_op2", 32'(i1.alu_op2), 0);
    check("rst_rsp_valid", 32'(i1.rsp_valid), 0);
    check("rst_rsp_result", 32'(i1.rsp_result), 0);
    check("rst_rsp_opcode", 32'(i1.rsp_opcode), 0);
    check("rst_busy", 32'(busy1), 0);
    rstn1 = 1'b1;
    rstn3 = 1'b1;
    check("rel_cmd_ready_first", 32'(i1.cmd_ready), 0);
    step();
    check("rel_cmd_ready_second", 32'(i1.cmd_ready), 1);
    check("rel_busy", 32'(busy1), 0);

    // Single operation and modulo wrap of the result.
    single_op(3'b101, 4'h3, 4'h4);
    single_op(3'b010, 4'hF, 4'h2);

    // Backpressure: response held five cycles, alu idle meanwhile.
    i1.rsp_ready = 1'b0;
    set_cmd1(3'b011, 4'h9, 4'h9);
    i1.cmd_valid = 1'b1;
    step();
    i1.cmd_valid = 1'b0;
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_rsp_valid", 32'(i1.rsp_valid), 1);
      check("bp_rsp_result", 32'(i1.rsp_result), 32'(4'h2));
      check("bp_rsp_opcode", 32'(i1.rsp_opcode), 32'(3'b011));
      check("bp_alu_idle", 32'({i1.alu_opcode, i1.alu_op1, i1.alu_op2}), 0);
    end
    i1.rsp_ready = 1'b1;
    step();
    check("bp_release", 32'(i1.rsp_valid), 0);

    // Fill: first command issues, four more fill the FIFO, sixth waits.
    i1.rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_cmd1(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      i1.cmd_valid = 1'b1;
      check("fill_cmd_ready", 32'(i1.cmd_ready), 1);
      step();
    end
    set_cmd1(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    check("full_cmd_ready_drop", 32'(i1.cmd_ready), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("full_hold_ready", 32'(i1.cmd_ready), 0);
      check("full_rsp_valid", 32'(i1.rsp_valid), 1);
    end
    i1.rsp_ready = 1'b1;
    step();                                   // response taken, back to IDLE
    check("full_still_full", 32'(i1.cmd_ready), 0);
    step();                                   // next issue pops one entry
    check("full_ready_after_pop", 32'(i1.cmd_ready), 1);
    step();                                   // sixth command accepted
    drain("full");

    // Randomized traffic against the in-order model.
    for (int k = 0; k < 300; k++) begin
      set_cmd1(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      i1.cmd_valid = ($urandom_range(0, 99) < 60);
      i1.rsp_ready = ($urandom_range(0, 99) < 70);
      step();
    end
    drain("rand");
    check("rand_end_ready", 32'(i1.cmd_ready), 1);
    check("rand_end_queue", 32'(exp_q.size()), 0);

    // Reset during WAIT on the ALU_LAT=3 instance with two commands queued.
    for (int k = 0; k < 3; k++) begin
      q_opc[k] = 3'(k + 1);
      i3.cmd_opcode = q_opc[k];
      i3.cmd_op1 = 4'(k);
      i3.cmd_op2 = 4'(k + 5);
      i3.cmd_valid = 1'b1;
      check("rw_cmd_ready", 32'(i3.cmd_ready), 1);
      step();
    end
    i3.cmd_valid = 1'b0;
    check("rw_issued", 32'(i3.alu_opcode), 32'(q_opc[0]));
    check("rw_busy_before", 32'(busy3), 1);
    check("rw_no_rsp_yet", 32'(i3.rsp_valid), 0);
    rstn3 = 1'b0;
    step();
    rstn3 = 1'b1;
    i3.rsp_ready = 1'b1;
    check("rw_alu_cleared", 32'(i3.alu_opcode), 0);
    check("rw_cmd_ready_low", 32'(i3.cmd_ready), 0);
    for (int k = 0; k < 10; k++) begin
      step();
      check("rw_no_rsp", 32'(i3.rsp_valid), 0);
      check("rw_busy_after", 32'(busy3), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
